// File: rtl/muldiv32.sv
// muldiv32 -- iterative 32-bit multiply/divide unit with HI/LO result registers.
// MULTU/MULT use radix-2 shift-add, DIVU/DIV use restoring division, one bit per
// cycle over 32 RUN cycles, followed by a two-cycle FIX (sign correction, then
// HI/LO write-back).
// Build option: define MULDIV_DIV_EN to include the divider datapath. Without it,
// divide ops complete immediately with a done pulse and leave HI/LO untouched.
module muldiv32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  op,
  input  logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_accept;
  logic         w_busy;
  logic         w_done;

  logic [5:0]   r_cnt;
  logic [63:0]  r_acc;
  logic [31:0]  r_mcand;
  logic         r_neg_a;
  logic         r_neg_b;
  logic [31:0]  r_hi;
  logic [31:0]  r_lo;
  logic         r_dbz_q;

  logic [31:0]  w_abs_a;
  logic [31:0]  w_abs_b;
  logic [32:0]  w_mul_sum;
  logic [63:0]  w_fix_acc;

`ifdef MULDIV_DIV_EN
  logic         r_is_div;
  logic         r_dbz;
  logic [32:0]  r_rem;
  logic [33:0]  w_div_sh;
  logic [33:0]  w_div_diff;
  logic         w_div_ge;
`endif

  // Magnitude of a 32-bit operand; the most negative value maps to itself.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negation, 32 bits.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  // Conditional two's-complement negation, 64 bits.
  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign HI          = r_hi;
  assign LO          = r_lo;
  assign busy        = w_busy;
  assign done        = w_done;
  assign div_by_zero = r_dbz_q;

  // Operand magnitudes and one iteration step of the shared datapath.
  always_comb begin
    w_abs_a   = abs32(A, op[0]);
    w_abs_b   = abs32(B, op[0]);
    w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
`ifdef MULDIV_DIV_EN
    w_div_sh   = {r_rem, r_acc[31]};
    w_div_diff = w_div_sh - {2'b00, r_mcand};
    w_div_ge   = ~w_div_diff[33];
`endif
  end

  // Sign-corrected result assembled during the first FIX cycle.
  always_comb begin
    w_fix_acc = neg64(r_acc, r_neg_a ^ r_neg_b);
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      w_fix_acc[63:32] = neg32(r_rem[31:0], r_neg_a);
      w_fix_acc[31:0]  = r_dbz ? 32'hFFFF_FFFF : neg32(r_acc[31:0], r_neg_a ^ r_neg_b);
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_busy      = (r_state == S_RUN) || (r_state == S_FIX);
    w_done      = (r_state == S_DONE);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
`ifdef MULDIV_DIV_EN
          w_state_nxt = S_RUN;
`else
          w_state_nxt = op[1] ? S_DONE : S_RUN;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN:   if (r_cnt == 6'd31) w_state_nxt = S_FIX;
      S_FIX:   if (r_cnt == 6'd33) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on accept, iteration in RUN, sign correction in FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 6'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 32'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_dbz    <= 1'b0;
      r_rem    <= 33'd0;
`endif
    end else if (w_accept) begin
      r_cnt   <= 6'd0;
      r_neg_a <= op[0] & A[31];
      r_neg_b <= op[0] & B[31];
`ifdef MULDIV_DIV_EN
      r_is_div <= op[1];
      r_dbz    <= op[1] && (B == 32'd0);
      r_rem    <= 33'd0;
      if (op[1]) begin
        r_mcand <= w_abs_b;
        r_acc   <= {32'd0, w_abs_a};
      end else begin
        r_mcand <= w_abs_a;
        r_acc   <= {32'd0, w_abs_b};
      end
`else
      r_mcand <= w_abs_a;
      r_acc   <= {32'd0, w_abs_b};
`endif
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 6'd1;
`ifdef MULDIV_DIV_EN
      if (r_is_div) begin
        r_rem        <= w_div_ge ? w_div_diff[32:0] : w_div_sh[32:0];
        r_acc[31:0]  <= {r_acc[30:0], w_div_ge};
      end else begin
        r_acc <= {w_mul_sum, r_acc[31:1]};
      end
`else
      r_acc <= {w_mul_sum, r_acc[31:1]};
`endif
    end else if (r_state == S_FIX) begin
      r_cnt <= r_cnt + 6'd1;
      if (r_cnt == 6'd32) r_acc <= w_fix_acc;
    end
  end

  // HI/LO and fault flag are written only on the FIX-to-DONE edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_dbz_q <= 1'b0;
    end else if ((r_state == S_FIX) && (r_cnt == 6'd33)) begin
      r_hi <= r_acc[63:32];
      r_lo <= r_acc[31:0];
`ifdef MULDIV_DIV_EN
      r_dbz_q <= r_dbz;
`else
      r_dbz_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv32.sv
// Directed testbench for muldiv32: multiply/divide results, latency, busy/done
// timing, ignored start, back-to-back start in DONE and mid-operation reset.
module tb_muldiv32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic        clk;
  logic        reset_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  op;
  logic        start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv32 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .A           (A),
    .B           (B),
    .op          (op),
    .start       (start),
    .HI          (HI),
    .LO          (LO),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an op with start high for one edge; returns just after the accept edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
  endtask

  // Observe 40 cycles after the accept edge: busy count, first done index, done count.
  task automatic watch(output int nb, output int fd, output int nd);
    nb = 0; fd = -1; nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (fd < 0) fd = k;
      end
      @(posedge clk); #1;
    end
  endtask

  // Wait (bounded) for done; k is the number of edges waited.
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_edge, input int exp_busy);
    int nb, fd, nd;
    launch(o, a, b);
    watch(nb, fd, nd);
    check({tag, ".done_edge"}, 64'(fd), 64'(exp_edge));
    check({tag, ".done_cnt"},  64'(nd), 64'd1);
    check({tag, ".busy_cnt"},  64'(nb), 64'(exp_busy));
  endtask

  initial begin
    int k, nb, fd, nd;
    reset_n = 1'b0; start = 1'b0; op = OP_MULTU; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.HI",   64'(HI), 64'd0);
    check("rst.LO",   64'(LO), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.dbz",  64'(div_by_zero), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 34);
    check("multu_max.HI", 64'(HI), 64'h0000_0000_FFFF_FFFE);
    check("multu_max.LO", 64'(LO), 64'h0000_0000_0000_0001);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 34, 34);
    check("mult_neg.HI", 64'(HI), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg.LO", 64'(LO), 64'h0000_0000_FFFF_FFF1);

    run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 34, 34);
    check("mult_min.HI", 64'(HI), 64'h0000_0000_4000_0000);
    check("mult_min.LO", 64'(LO), 64'd0);

`ifdef MULDIV_DIV_EN
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 34);
    check("div_neg.LO", 64'(LO), 64'h0000_0000_FFFF_FFFD);
    check("div_neg.HI", 64'(HI), 64'h0000_0000_FFFF_FFFF);

    run_op("divu", OP_DIVU, 32'd100, 32'd7, 34, 34);
    check("divu.LO", 64'(LO), 64'd14);
    check("divu.HI", 64'(HI), 64'd2);

    run_op("divu_z", OP_DIVU, 32'h64, 32'd0, 34, 34);
    check("divu_z.LO",  64'(LO), 64'h0000_0000_FFFF_FFFF);
    check("divu_z.HI",  64'(HI), 64'h64);
    check("divu_z.dbz", 64'(div_by_zero), 64'd1);

    run_op("mul_clr", OP_MULTU, 32'd2, 32'd3, 34, 34);
    check("mul_clr.dbz", 64'(div_by_zero), 64'd0);
    check("mul_clr.LO",  64'(LO), 64'd6);

    run_op("div_z_neg", OP_DIV, 32'hFFFF_FFFB, 32'd0, 34, 34);
    check("div_z_neg.LO",  64'(LO), 64'h0000_0000_FFFF_FFFF);
    check("div_z_neg.HI",  64'(HI), 64'h0000_0000_FFFF_FFFB);
    check("div_z_neg.dbz", 64'(div_by_zero), 64'd1);

    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 34);
    check("div_ovf.LO",  64'(LO), 64'h0000_0000_8000_0000);
    check("div_ovf.HI",  64'(HI), 64'd0);
    check("div_ovf.dbz", 64'(div_by_zero), 64'd0);
`else
    run_op("mul_pre", OP_MULTU, 32'h0001_0000, 32'h0003_0005, 34, 34);
    check("mul_pre.HI", 64'(HI), 64'd3);
    check("mul_pre.LO", 64'(LO), 64'h0005_0000);

    run_op("div_off", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_off.HI",  64'(HI), 64'd3);
    check("div_off.LO",  64'(LO), 64'h0005_0000);
    check("div_off.dbz", 64'(div_by_zero), 64'd0);

    run_op("divu_off_z", OP_DIVU, 32'd100, 32'd0, 0, 0);
    check("divu_off_z.HI",  64'(HI), 64'd3);
    check("divu_off_z.LO",  64'(LO), 64'h0005_0000);
    check("divu_off_z.dbz", 64'(div_by_zero), 64'd0);
`endif

    // Back-to-back: new start while done is high.
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_done(k);
    check("b2b.first_edge", 64'(k), 64'd34);
    check("b2b.first_LO",   64'(LO), 64'd42);
    op = OP_MULTU; A = 32'h0001_0000; B = 32'h0001_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 32'd0; B = 32'd0;
    check("b2b.busy", 64'(busy), 64'd1);
    check("b2b.done", 64'(done), 64'd0);
    wait_done(k);
    check("b2b.second_edge", 64'(k), 64'd34);
    check("b2b.HI", 64'(HI), 64'd1);
    check("b2b.LO", 64'(LO), 64'd0);
    @(posedge clk); #1;
    check("b2b.done_1cyc", 64'(done), 64'd0);

    // start while running is ignored.
    launch(OP_MULTU, 32'd3, 32'd3);
    repeat (9) begin
      @(posedge clk); #1;
    end
    op = OP_MULTU; A = 32'd5; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(k);
    check("ign.edge", 64'(k), 64'd24);
    check("ign.LO",   64'(LO), 64'd9);
    check("ign.HI",   64'(HI), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation aborts and clears.
    launch(OP_MULTU, 32'd3, 32'd3);
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.HI",   64'(HI), 64'd0);
    check("mrst.LO",   64'(LO), 64'd0);
    check("mrst.done", 64'(done), 64'd0);
    #2;
    reset_n = 1'b1;
    watch(nb, fd, nd);
    check("mrst.no_done", 64'(nd), 64'd0);
    check("mrst.no_busy", 64'(nb), 64'd0);
    check("mrst.LO_hold", 64'(LO), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
